// File: rtl/seven_seg_digit_driver.sv
// Binary-to-BCD digit driver for a scanned 4-digit seven-segment display.
// A sequential double-dabble engine fills a display register that the anode scan reads back.
`timescale 1ns/1ps
module seven_seg_digit_driver #(
    parameter bit         BLANK_LZ = 1'b1,
    parameter logic [3:0] DP_MASK  = 4'b0000
) (
    input  logic        div_clock,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        load,
    input  logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    state_t      r_state;
    logic [29:0] r_shift;
    logic [3:0]  r_count;
    logic [15:0] r_disp;
    logic        r_dash;
    logic        r_busy;
    logic        r_overflow;

    logic [29:0] w_next;
    logic [3:0]  w_digit;
    logic [1:0]  w_idx;
    logic        w_valid;
    logic        w_blank;
    logic        w_th_z;
    logic        w_hu_z;
    logic        w_te_z;

    // One double-dabble step: correct each BCD nibble, then shift the whole register.
    function automatic logic [29:0] dabble_step(input logic [29:0] s);
        logic [29:0] t;
        t = s;
        for (int k = 0; k < 4; k++) begin
            if (t[14+4*k +: 4] >= 4'd5)
                t[14+4*k +: 4] = t[14+4*k +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    always_comb w_next = dabble_step(r_shift);

    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_count    <= '0;
            r_disp     <= '0;
            r_dash     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        if (value <= 14'd9999) begin
                            r_shift <= {16'b0, value};
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_CONVERT;
                        end else begin
                            // Out-of-range value keeps the old digits; only the dash overlay changes.
                            r_overflow <= 1'b1;
                            r_dash     <= 1'b1;
                        end
                    end
                end
                S_CONVERT: begin
                    r_shift <= w_next;
                    r_count <= r_count + 4'd1;
                    if (r_count == 4'd13) begin
                        r_disp     <= w_next[29:14];
                        r_dash     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign overflow = r_overflow;

    assign w_th_z = (r_disp[15:12] == 4'd0);
    assign w_hu_z = w_th_z && (r_disp[11:8] == 4'd0);
    assign w_te_z = w_hu_z && (r_disp[7:4] == 4'd0);

    always_comb begin
        w_valid = 1'b1;
        w_idx   = 2'd0;
        w_digit = r_disp[3:0];
        w_blank = 1'b0;
        case (anode)
            4'b1110: begin w_idx = 2'd0; w_digit = r_disp[3:0];   w_blank = 1'b0;              end
            4'b1101: begin w_idx = 2'd1; w_digit = r_disp[7:4];   w_blank = BLANK_LZ && w_te_z; end
            4'b1011: begin w_idx = 2'd2; w_digit = r_disp[11:8];  w_blank = BLANK_LZ && w_hu_z; end
            4'b0111: begin w_idx = 2'd3; w_digit = r_disp[15:12]; w_blank = BLANK_LZ && w_th_z; end
            default: w_valid = 1'b0;
        endcase
    end

    // Blanked digits still honour their decimal point; the dash overlay suppresses it.
    always_comb begin
        cathode = SEG_BLANK;
        dp      = 1'b1;
        if (w_valid) begin
            if (r_dash) begin
                cathode = SEG_DASH;
            end else begin
                cathode = w_blank ? SEG_BLANK : seg_code(w_digit);
                dp      = ~DP_MASK[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed bench for seven_seg_digit_driver: two instances cover BLANK_LZ=1/DP_MASK=0
// and BLANK_LZ=0/DP_MASK=0100 from one shared stimulus stream.
`timescale 1ns/1ps
module tb_seven_seg_digit_driver;

    logic        div_clock = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        load;
    logic [3:0]  anode;
    logic [6:0]  cathode, cathode2;
    logic        dp, dp2, busy, busy2, overflow, overflow2;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;

    seven_seg_digit_driver #(.BLANK_LZ(1'b1), .DP_MASK(4'b0000)) dut (
        .div_clock(div_clock), .reset(reset), .value(value), .load(load), .anode(anode),
        .cathode(cathode), .dp(dp), .busy(busy), .overflow(overflow));

    seven_seg_digit_driver #(.BLANK_LZ(1'b0), .DP_MASK(4'b0100)) dut2 (
        .div_clock(div_clock), .reset(reset), .value(value), .load(load), .anode(anode),
        .cathode(cathode2), .dp(dp2), .busy(busy2), .overflow(overflow2));

    always #10 div_clock = ~div_clock;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge div_clock);
        #1;
    endtask

    task automatic chk_an(input string tag, input logic [3:0] an, input logic [6:0] c, input logic d);
        anode = an;
        #1;
        chk({tag, "_cath"}, cathode, c);
        chk({tag, "_dp"}, dp, d);
    endtask

    task automatic do_load(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Counts samples with busy high from now until it drops, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
        if (n >= 40) chk("busy_timeout", 1, 0);
    endtask

    int n;

    initial begin
        reset = 1'b1; value = '0; load = 1'b0; anode = 4'b1110;
        #25;
        chk_an("rst_ones", 4'b1110, S0, 1'b1);
        chk_an("rst_tens", 4'b1101, SB, 1'b1);
        chk_an("rst_hund", 4'b1011, SB, 1'b1);
        chk_an("rst_thou", 4'b0111, SB, 1'b1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy2", busy2, 0);
        @(negedge div_clock);
        reset = 1'b0;
        step();

        // 1234: exactly 14 busy cycles, display untouched until the end
        do_load(14'd1234);
        value = 14'd9999;
        chk("conv_busy_start", busy, 1);
        chk_an("conv_mid_ones", 4'b1110, S0, 1'b1);
        wait_idle(n);
        chk("busy_len_1234", n, 14);
        chk_an("d1234_ones", 4'b1110, S4, 1'b1);
        chk_an("d1234_tens", 4'b1101, S3, 1'b1);
        chk_an("d1234_hund", 4'b1011, S2, 1'b1);
        chk_an("d1234_thou", 4'b0111, S1, 1'b1);

        // 10000: overflow, dash on all digits, no conversion
        do_load(14'd10000);
        chk("ovf_10000", overflow, 1);
        chk("ovf_busy", busy, 0);
        chk_an("dash_ones", 4'b1110, SD, 1'b1);
        chk_an("dash_tens", 4'b1101, SD, 1'b1);
        chk_an("dash_hund", 4'b1011, SD, 1'b1);
        chk_an("dash_thou", 4'b0111, SD, 1'b1);
        anode = 4'b1011; #1;
        chk("dash_dp2", dp2, 1);

        do_load(14'd9999);
        wait_idle(n);
        chk("busy_len_9999", n, 14);
        chk("ovf_cleared", overflow, 0);
        chk_an("d9999_ones", 4'b1110, S9, 1'b1);
        chk_an("d9999_tens", 4'b1101, S9, 1'b1);
        chk_an("d9999_hund", 4'b1011, S9, 1'b1);
        chk_an("d9999_thou", 4'b0111, S9, 1'b1);

        do_load(14'd16383);
        chk("ovf_16383", overflow, 1);
        chk("ovf2_16383", overflow2, 1);
        chk("ovf_busy_max", busy, 0);
        chk_an("dash_max", 4'b1101, SD, 1'b1);

        // 7: leading-zero blanking vs. full display, dp mask on hundreds
        do_load(14'd7);
        wait_idle(n);
        chk_an("d7_ones", 4'b1110, S7, 1'b1);
        chk_an("d7_tens", 4'b1101, SB, 1'b1);
        chk_an("d7_hund", 4'b1011, SB, 1'b1);
        chk("d7_hund_cath2", cathode2, S0);
        chk("d7_hund_dp2", dp2, 0);
        chk_an("d7_thou", 4'b0111, SB, 1'b1);
        chk("d7_thou_cath2", cathode2, S0);
        chk("d7_thou_dp2", dp2, 1);

        // 1050 exercises blanking with an interior zero digit
        do_load(14'd1050);
        wait_idle(n);
        chk_an("d1050_ones", 4'b1110, S0, 1'b1);
        chk_an("d1050_tens", 4'b1101, S5, 1'b1);
        chk_an("d1050_hund", 4'b1011, S0, 1'b1);
        chk_an("d1050_thou", 4'b0111, S1, 1'b1);

        // 0 shows a single "0"
        do_load(14'd0);
        wait_idle(n);
        chk_an("d0_ones", 4'b1110, S0, 1'b1);
        chk_an("d0_tens", 4'b1101, SB, 1'b1);

        // load while busy is dropped
        do_load(14'd1234);
        repeat (4) step();
        value = 14'd5678;
        load  = 1'b1;
        step();
        load  = 1'b0;
        wait_idle(n);
        chk("busy_len_ignored", n, 9);
        step();
        chk("no_queued_load", busy, 0);
        chk_an("ign_ones", 4'b1110, S4, 1'b1);
        chk_an("ign_thou", 4'b0111, S1, 1'b1);

        // reset at busy cycle 8 aborts and zeroes the display
        do_load(14'd5678);
        repeat (7) step();
        chk("pre_abort_busy", busy, 1);
        chk_an("pre_abort_thou", 4'b0111, S1, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk_an("abort_ones", 4'b1110, S0, 1'b1);
        chk_an("abort_thou", 4'b0111, SB, 1'b1);
        @(negedge div_clock);
        reset = 1'b0;
        step();
        chk("abort_stays_idle", busy, 0);

        // invalid anode patterns
        do_load(14'd8086);
        wait_idle(n);
        chk_an("d8086_ones", 4'b1110, S6, 1'b1);
        chk_an("d8086_thou", 4'b0111, S8, 1'b1);
        chk_an("an_1111", 4'b1111, SB, 1'b1);
        chk_an("an_1100", 4'b1100, SB, 1'b1);
        chk_an("an_0000", 4'b0000, SB, 1'b1);
        chk("an_0000_cath2", cathode2, SB);
        anode = 4'b1011; #1;
        chk("dp2_hund", dp2, 0);
        chk("cath2_hund", cathode2, S0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
